// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - ISA opcode and EX command encodings shared by the pipeline stages
package isa_pkg;

    typedef enum logic [5:0] {
        OP_NOP  = 6'd0,
        OP_ADD  = 6'd1,
        OP_SUB  = 6'd3,
        OP_AND  = 6'd5,
        OP_OR   = 6'd6,
        OP_NOR  = 6'd7,
        OP_XOR  = 6'd8,
        OP_SLA  = 6'd9,
        OP_SLL  = 6'd10,
        OP_SRA  = 6'd11,
        OP_SRL  = 6'd12,
        OP_ADDI = 6'd32,
        OP_SUBI = 6'd33,
        OP_LD   = 6'd36,
        OP_ST   = 6'd37,
        OP_BEZ  = 6'd40,
        OP_BNE  = 6'd41,
        OP_JMP  = 6'd42
    } opcode_e;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_AND = 4'd3,
        CMD_OR  = 4'd4,
        CMD_NOR = 4'd5,
        CMD_XOR = 4'd6,
        CMD_SLA = 4'd7,
        CMD_SLL = 4'd8,
        CMD_SRA = 4'd9,
        CMD_SRL = 4'd10
    } cmd_e;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - general register file, R0 hardwired to zero, write-through bypass on reads
module reg_file
    import isa_pkg::*;
#(
    parameter int REG_NUM = 32
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic [4:0]  rd_addr_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] rd_data_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs_q [REG_NUM];

    // A read of the register being written this cycle sees the new value.
    assign rs1_data_o = (rs1_addr_i == 5'd0) ? 32'd0 :
                        (we_i && waddr_i == rs1_addr_i) ? wdata_i : regs_q[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == 5'd0) ? 32'd0 :
                        (we_i && waddr_i == rs2_addr_i) ? wdata_i : regs_q[rs2_addr_i];
    assign rd_data_o  = (rd_addr_i == 5'd0) ? 32'd0 :
                        (we_i && waddr_i == rd_addr_i) ? wdata_i : regs_q[rd_addr_i];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && waddr_i != 5'd0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode stage: decode, register read, branch resolve, ID/EX register
module id_stage
    import isa_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int REG_NUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              stall,
    input  logic              wb_en,
    input  logic [4:0]        wb_dest,
    input  logic [31:0]       wb_value,
    output logic              branch_taken,
    output logic [ADDR_W-1:0] branch_address,
    output logic [ADDR_W-1:0] ex_pc,
    output logic [3:0]        ex_cmd,
    output logic [31:0]       ex_val1,
    output logic [31:0]       ex_val2,
    output logic [31:0]       ex_st_val,
    output logic [4:0]        ex_dest,
    output logic              ex_wb_en,
    output logic              ex_mem_r,
    output logic              ex_mem_w,
    output logic              illegal_op
);

    logic [5:0]  opcode;
    logic [4:0]  dest;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] src1_val;
    logic [31:0] src2_val;
    logic [31:0] dest_val;

    assign opcode   = instruction_in[31:26];
    assign dest     = instruction_in[25:21];
    assign src1     = instruction_in[20:16];
    assign src2     = instruction_in[15:11];
    assign imm      = instruction_in[15:0];
    assign imm_sext = sext16(imm);

    reg_file #(.REG_NUM(REG_NUM)) u_reg_file (
        .clk_i      (clk),
        .rstn_i     (rst),
        .rs1_addr_i (src1),
        .rs2_addr_i (src2),
        .rd_addr_i  (dest),
        .rs1_data_o (src1_val),
        .rs2_data_o (src2_val),
        .rd_data_o  (dest_val),
        .we_i       (wb_en),
        .waddr_i    (wb_dest),
        .wdata_i    (wb_value)
    );

    logic [3:0]  cmd_dec;
    logic [31:0] val2_dec;
    logic [31:0] st_val_dec;
    logic        wb_en_dec;
    logic        mem_r_dec;
    logic        mem_w_dec;
    logic        illegal_dec;
    logic        bubble_dec;
    logic        branch_cond;

    always_comb begin
        cmd_dec     = CMD_NOP;
        val2_dec    = src2_val;
        st_val_dec  = '0;
        wb_en_dec   = 1'b0;
        mem_r_dec   = 1'b0;
        mem_w_dec   = 1'b0;
        illegal_dec = 1'b0;
        bubble_dec  = 1'b0;
        branch_cond = 1'b0;
        case (opcode)
            OP_NOP:  bubble_dec = 1'b1;
            OP_ADD:  begin cmd_dec = CMD_ADD; wb_en_dec = 1'b1; end
            OP_SUB:  begin cmd_dec = CMD_SUB; wb_en_dec = 1'b1; end
            OP_AND:  begin cmd_dec = CMD_AND; wb_en_dec = 1'b1; end
            OP_OR:   begin cmd_dec = CMD_OR;  wb_en_dec = 1'b1; end
            OP_NOR:  begin cmd_dec = CMD_NOR; wb_en_dec = 1'b1; end
            OP_XOR:  begin cmd_dec = CMD_XOR; wb_en_dec = 1'b1; end
            OP_SLA:  begin cmd_dec = CMD_SLA; wb_en_dec = 1'b1; end
            OP_SLL:  begin cmd_dec = CMD_SLL; wb_en_dec = 1'b1; end
            OP_SRA:  begin cmd_dec = CMD_SRA; wb_en_dec = 1'b1; end
            OP_SRL:  begin cmd_dec = CMD_SRL; wb_en_dec = 1'b1; end
            OP_ADDI: begin cmd_dec = CMD_ADD; val2_dec = imm_sext; wb_en_dec = 1'b1; end
            OP_SUBI: begin cmd_dec = CMD_SUB; val2_dec = imm_sext; wb_en_dec = 1'b1; end
            OP_LD: begin
                cmd_dec   = CMD_ADD;
                val2_dec  = imm_sext;
                mem_r_dec = 1'b1;
                wb_en_dec = 1'b1;
            end
            OP_ST: begin
                cmd_dec    = CMD_ADD;
                val2_dec   = imm_sext;
                st_val_dec = dest_val;
                mem_w_dec  = 1'b1;
            end
            // Branches resolve here and travel to EX as bubbles.
            OP_BEZ: begin bubble_dec = 1'b1; branch_cond = (dest_val == 32'd0); end
            OP_BNE: begin bubble_dec = 1'b1; branch_cond = (dest_val != src1_val); end
            OP_JMP: begin bubble_dec = 1'b1; branch_cond = 1'b1; end
            default: begin bubble_dec = 1'b1; illegal_dec = 1'b1; end
        endcase
    end

    logic squash_q;
    logic squash_d;
    logic issue_ok;

    // The slot right after a taken branch holds a wrong-path instruction.
    assign issue_ok       = rst && !stall && !squash_q;
    assign branch_taken   = issue_ok && branch_cond;
    assign branch_address = pc_in + ADDR_W'(4) + {{(ADDR_W-18){imm[15]}}, imm, 2'b00};

    always_comb begin
        squash_d = squash_q;
        if (!rst) begin
            squash_d = 1'b0;
        end else if (!stall) begin
            squash_d = branch_taken;
        end
    end

    logic [ADDR_W-1:0] ex_pc_d, ex_pc_q;
    logic [3:0]        ex_cmd_d, ex_cmd_q;
    logic [31:0]       ex_val1_d, ex_val1_q;
    logic [31:0]       ex_val2_d, ex_val2_q;
    logic [31:0]       ex_st_val_d, ex_st_val_q;
    logic [4:0]        ex_dest_d, ex_dest_q;
    logic              ex_wb_en_d, ex_wb_en_q;
    logic              ex_mem_r_d, ex_mem_r_q;
    logic              ex_mem_w_d, ex_mem_w_q;
    logic              illegal_d, illegal_q;

    always_comb begin
        ex_pc_d     = '0;
        ex_cmd_d    = CMD_NOP;
        ex_val1_d   = '0;
        ex_val2_d   = '0;
        ex_st_val_d = '0;
        ex_dest_d   = '0;
        ex_wb_en_d  = 1'b0;
        ex_mem_r_d  = 1'b0;
        ex_mem_w_d  = 1'b0;
        illegal_d   = 1'b0;
        if (issue_ok) begin
            illegal_d = illegal_dec;
            if (!bubble_dec) begin
                ex_pc_d     = pc_in;
                ex_cmd_d    = cmd_dec;
                ex_val1_d   = src1_val;
                ex_val2_d   = val2_dec;
                ex_st_val_d = st_val_dec;
                ex_dest_d   = dest;
                ex_wb_en_d  = wb_en_dec;
                ex_mem_r_d  = mem_r_dec;
                ex_mem_w_d  = mem_w_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            squash_q    <= 1'b0;
            ex_pc_q     <= '0;
            ex_cmd_q    <= '0;
            ex_val1_q   <= '0;
            ex_val2_q   <= '0;
            ex_st_val_q <= '0;
            ex_dest_q   <= '0;
            ex_wb_en_q  <= 1'b0;
            ex_mem_r_q  <= 1'b0;
            ex_mem_w_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            squash_q    <= squash_d;
            ex_pc_q     <= ex_pc_d;
            ex_cmd_q    <= ex_cmd_d;
            ex_val1_q   <= ex_val1_d;
            ex_val2_q   <= ex_val2_d;
            ex_st_val_q <= ex_st_val_d;
            ex_dest_q   <= ex_dest_d;
            ex_wb_en_q  <= ex_wb_en_d;
            ex_mem_r_q  <= ex_mem_r_d;
            ex_mem_w_q  <= ex_mem_w_d;
            illegal_q   <= illegal_d;
        end
    end

    assign ex_pc      = ex_pc_q;
    assign ex_cmd     = ex_cmd_q;
    assign ex_val1    = ex_val1_q;
    assign ex_val2    = ex_val2_q;
    assign ex_st_val  = ex_st_val_q;
    assign ex_dest    = ex_dest_q;
    assign ex_wb_en   = ex_wb_en_q;
    assign ex_mem_r   = ex_mem_r_q;
    assign ex_mem_w   = ex_mem_w_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - randomized self-checking bench for id_stage against a behavioural model
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction_in;
    logic [31:0] pc_in;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_value;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [31:0] ex_pc;
    logic [3:0]  ex_cmd;
    logic [31:0] ex_val1, ex_val2, ex_st_val;
    logic [4:0]  ex_dest;
    logic        ex_wb_en, ex_mem_r, ex_mem_w, illegal_op;

    always #5 clk = ~clk;

    id_stage #(.ADDR_W(32), .REG_NUM(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .instruction_in (instruction_in),
        .pc_in          (pc_in),
        .stall          (stall),
        .wb_en          (wb_en),
        .wb_dest        (wb_dest),
        .wb_value       (wb_value),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .ex_pc          (ex_pc),
        .ex_cmd         (ex_cmd),
        .ex_val1        (ex_val1),
        .ex_val2        (ex_val2),
        .ex_st_val      (ex_st_val),
        .ex_dest        (ex_dest),
        .ex_wb_en       (ex_wb_en),
        .ex_mem_r       (ex_mem_r),
        .ex_mem_w       (ex_mem_w),
        .illegal_op     (illegal_op)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cmd;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] st;
        logic [4:0]  dest;
        logic        wb;
        logic        mr;
        logic        mw;
        logic        ill;
    } exp_t;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] m_regs [32];
    logic        m_squash;
    logic        last_bt;
    logic [31:0] last_ba;
    int          r_ops [10]     = '{1, 3, 5, 6, 7, 8, 9, 10, 11, 12};
    int          legal_ops [18] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_dest == a) return wb_value;
        return m_regs[a];
    endfunction

    task automatic predict(output exp_t e, output logic bt, output logic [31:0] ba);
        int          op;
        int          ri;
        logic [31:0] simm;
        logic [4:0]  d, s1, s2;
        op   = int'(instruction_in[31:26]);
        d    = instruction_in[25:21];
        s1   = instruction_in[20:16];
        s2   = instruction_in[15:11];
        simm = 32'($signed(instruction_in[15:0]));
        ba   = pc_in + 32'd4 + simm * 32'd4;
        e    = '0;
        bt   = 1'b0;
        if (!rst || stall || m_squash) return;
        ri = -1;
        foreach (r_ops[k]) if (r_ops[k] == op) ri = k;
        if (ri >= 0) begin
            e.pc = pc_in; e.cmd = 4'(ri + 1); e.v1 = m_read(s1); e.v2 = m_read(s2);
            e.dest = d; e.wb = 1'b1;
        end else begin
            case (op)
                0: ;
                32, 33, 36, 37: begin
                    e.pc   = pc_in;
                    e.cmd  = (op == 33) ? 4'd2 : 4'd1;
                    e.v1   = m_read(s1);
                    e.v2   = simm;
                    e.dest = d;
                    e.wb   = (op != 37);
                    e.mr   = (op == 36);
                    e.mw   = (op == 37);
                    e.st   = (op == 37) ? m_read(d) : 32'd0;
                end
                40: bt = (m_read(d) == 32'd0);
                41: bt = (m_read(d) != m_read(s1));
                42: bt = 1'b1;
                default: e.ill = 1'b1;
            endcase
        end
    endtask

    task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pc, input logic st,
                        input logic we, input logic [4:0] wd, input logic [31:0] wv);
        exp_t        e;
        logic        bt;
        logic [31:0] ba;
        @(negedge clk);
        rst = r; instruction_in = ins; pc_in = pc; stall = st;
        wb_en = we; wb_dest = wd; wb_value = wv;
        #1;
        predict(e, bt, ba);
        check("branch_taken", branch_taken, bt);
        check("branch_address", branch_address, ba);
        last_bt = branch_taken;
        last_ba = branch_address;
        @(posedge clk);
        #1;
        check("ex_pc", ex_pc, e.pc);
        check("ex_cmd", ex_cmd, e.cmd);
        check("ex_val1", ex_val1, e.v1);
        check("ex_val2", ex_val2, e.v2);
        check("ex_st_val", ex_st_val, e.st);
        check("ex_dest", ex_dest, e.dest);
        check("ex_wb_en", ex_wb_en, e.wb);
        check("ex_mem_r", ex_mem_r, e.mr);
        check("ex_mem_w", ex_mem_w, e.mw);
        check("illegal_op", illegal_op, e.ill);
        if (!r) begin
            foreach (m_regs[i]) m_regs[i] = 32'd0;
            m_squash = 1'b0;
        end else begin
            if (we && wd != 5'd0) m_regs[wd] = wv;
            if (bt) m_squash = 1'b1;
            else if (!st) m_squash = 1'b0;
        end
    endtask

    function automatic logic [31:0] enc_r(input int op, input int d, input int s1, input int s2);
        return {6'(op), 5'(d), 5'(s1), 5'(s2), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int d, input int s1, input logic [15:0] im);
        return {6'(op), 5'(d), 5'(s1), im};
    endfunction

    initial begin
        logic [31:0] ins;
        int          op;
        rst = 1'b0; instruction_in = '0; pc_in = '0; stall = 1'b0;
        wb_en = 1'b0; wb_dest = '0; wb_value = '0;
        foreach (m_regs[i]) m_regs[i] = 32'd0;
        m_squash = 1'b0;

        step(0, 32'd0, 32'd0, 0, 0, 0, 0);
        step(0, enc_r(1, 1, 2, 3), 32'h40, 0, 0, 0, 0);
        check("reset_ex_cmd", ex_cmd, 0);
        check("reset_ex_wb_en", ex_wb_en, 0);
        check("reset_illegal", illegal_op, 0);

        step(1, enc_i(32, 5, 6, 16'd2), 32'h100, 0, 0, 0, 0);
        check("addi_cmd", ex_cmd, 1);
        check("addi_val1", ex_val1, 0);
        check("addi_val2", ex_val2, 2);
        check("addi_dest", ex_dest, 5);
        check("addi_wb_en", ex_wb_en, 1);

        step(1, enc_r(1, 4, 3, 0), 32'h104, 0, 1, 3, 32'h1234);
        check("bypass_val1", ex_val1, 32'h1234);

        step(1, enc_i(40, 11, 0, 16'd3), 32'd60, 0, 0, 0, 0);
        check("bez_taken", last_bt, 1);
        check("bez_addr", last_ba, 76);
        step(1, enc_r(3, 2, 3, 3), 32'd64, 0, 0, 0, 0);
        check("squash_wb_en", ex_wb_en, 0);
        check("squash_cmd", ex_cmd, 0);

        step(1, enc_i(41, 13, 14, 16'd5), 32'd68, 0, 0, 0, 0);
        check("bne_equal_taken", last_bt, 0);
        step(1, enc_r(1, 2, 3, 3), 32'd72, 0, 0, 0, 0);
        check("after_bne_wb_en", ex_wb_en, 1);
        check("after_bne_val1", ex_val1, 32'h1234);

        step(1, enc_i(42, 0, 0, 16'hfffe), 32'd76, 1, 0, 0, 0);
        check("jmp_stall_taken", last_bt, 0);
        check("jmp_stall_cmd", ex_cmd, 0);
        step(1, enc_i(42, 0, 0, 16'hfffe), 32'd76, 0, 0, 0, 0);
        check("jmp_taken", last_bt, 1);
        check("jmp_addr", last_ba, 72);
        step(1, enc_r(1, 2, 3, 3), 32'd80, 0, 0, 0, 0);

        step(1, {6'd63, 26'd0}, 32'd84, 0, 0, 0, 0);
        check("illegal_pulse", illegal_op, 1);
        check("illegal_cmd", ex_cmd, 0);
        step(1, 32'd0, 32'd88, 0, 0, 0, 0);
        check("illegal_clear", illegal_op, 0);

        step(1, enc_r(1, 7, 0, 0), 32'd92, 0, 1, 0, 32'hdead);
        check("r0_bypass", ex_val1, 0);
        step(1, enc_r(1, 7, 0, 0), 32'd96, 0, 0, 0, 0);
        check("r0_read", ex_val1, 0);

        step(1, enc_i(42, 0, 0, 16'd0), 32'hffff_fffc, 0, 0, 0, 0);
        check("wrap_addr", last_ba, 0);
        step(0, enc_i(42, 0, 0, 16'd1), 32'd200, 0, 0, 0, 0);
        check("reset_branch_taken", last_bt, 0);
        step(1, enc_i(32, 1, 0, 16'd7), 32'd204, 0, 0, 0, 0);
        check("post_reset_issue", ex_wb_en, 1);
        check("post_reset_val2", ex_val2, 7);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 17)];
            else op = int'($urandom_range(0, 63));
            ins = {6'(op), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            step($urandom_range(0, 49) != 0, ins, $urandom & 32'hffff_fffc,
                 $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 2)) : $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter ADDR_W, default 32, width of pc_in, branch_address and ex_pc.
REQ-002 Parameter REG_NUM, default 32, number of general registers (5-bit index).
REQ-003 clk  in  1  sole clock, all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-low (asserted when 0).
REQ-005 instruction_in  in  32  instruction from IF/ID register: opcode[31:26], dest[25:21], src1[20:16], src2[15:11], imm[15:0].
REQ-006 pc_in  in  ADDR_W  byte address of instruction_in.
REQ-007 stall  in  1  hazard freeze; current instruction must not issue this cycle.
REQ-008 wb_en, wb_dest[4:0], wb_value[31:0]  in  writeback port from WB stage.
REQ-009 branch_taken  out  1  combinational, PC redirect request to IF stage.
REQ-010 branch_address  out  ADDR_W  combinational redirect target.
REQ-011 ex_pc  out  ADDR_W; ex_cmd  out  4; ex_val1, ex_val2, ex_st_val  out  32; ex_dest  out  5; ex_wb_en, ex_mem_r, ex_mem_w, illegal_op  out  1 each; all registered (ID/EX register).

Function
REQ-012 Opcode map SHALL be: 0 NOP, 1 ADD, 3 SUB, 5 AND, 6 OR, 7 NOR, 8 XOR, 9 SLA, 10 SLL, 11 SRA, 12 SRL, 32 ADDI, 33 SUBI, 36 LD, 37 ST, 40 BEZ, 41 BNE, 42 JMP; ex_cmd codes 0..10 = NOP,ADD,SUB,AND,OR,NOR,XOR,SLA,SLL,SRA,SRL.
REQ-013 R-type (1..12): ex_val1=R[src1], ex_val2=R[src2], ex_dest=dest, ex_wb_en=1.
REQ-014 ADDI/SUBI: ex_val2=sign-extended imm, ex_cmd ADD/SUB, ex_wb_en=1.
REQ-015 LD: ex_cmd=ADD, ex_val2=sext(imm), ex_mem_r=1, ex_wb_en=1; ST: ex_cmd=ADD, ex_val2=sext(imm), ex_st_val=R[dest], ex_mem_w=1, ex_wb_en=0.
REQ-016 BEZ taken when R[dest]==0; BNE taken when R[dest]!=R[src1]; JMP always taken.
REQ-017 branch_address SHALL equal pc_in+4+(sext(imm)<<2), modulo 2^ADDR_W (wrap-around permitted).
REQ-018 Branches SHALL issue as NOP bubbles to EX (no writeback, no memory access).
REQ-019 R0 SHALL read as 0 always; writes to R0 ignored.
REQ-020 Register file written at posedge when wb_en=1; same-cycle read of wb_dest SHALL return wb_value (write-through bypass).
REQ-021 Cycle after branch_taken, incoming instruction is wrong-path: a squash flag SHALL force it to issue as NOP and suppress its branch_taken; flag clears after one consumed instruction.
REQ-022 stall=1: ID/EX register loads NOP bubble, branch_taken forced 0, squash flag held; writeback still performed.
REQ-023 Unlisted opcode: issues as NOP; illegal_op=1 for that issue cycle only.
REQ-024 Latency: instruction at posedge N inputs appears on ex_* after posedge N.

Reset
REQ-025 rst=0 at posedge: all ex_* outputs 0 (NOP bubble), illegal_op 0, squash flag 0, all registers 0.
REQ-026 Reset mid-branch SHALL drop any pending squash; branch_taken forced 0 while rst=0.

Structure
REQ-027 Opcode and ex_cmd encodings SHALL live in shared package isa_pkg for reuse by IF/EX stages.
REQ-028 Register file SHALL be sub-module reg_file (2 read ports plus dest read port, 1 write port, bypass inside).

Verification
REQ-029 Reset, then ADDI r5 r6 2 with R6=0 -> ex_cmd=ADD, ex_val1=0, ex_val2=2, ex_dest=5, ex_wb_en=1 one cycle later.
REQ-030 wb r3=0x1234 same cycle as ADD reading r3 -> ex_val1=0x1234.
REQ-031 BEZ r11 imm=3 at pc 60, R11=0 -> branch_taken=1, branch_address=76; next instruction (SUB) issues as NOP, ex_wb_en=0.
REQ-032 BNE r13 r14 with equal values -> branch_taken=0, next instruction issues normally.
REQ-033 stall=1 during JMP -> branch_taken=0, NOP issued; stall released -> branch_taken=1.
REQ-034 Opcode 63 -> NOP issued, illegal_op pulses one cycle; write to R0 then read -> 0.
